ram_access_ctrl: RTL
====================

Name: ram_access_ctrl

Overview:
- Initiator-side controller for the single-port block RAM. Drives `ena`/`wea`/`addra`/`dina` and captures `douta`.
- Accepts CPU load/store requests on a valid/ready interface and returns read data on a valid/ready response channel.
- Absorbs the RAM's fixed read latency.
- Provides a hardware clear sequence that writes CLEAR_VAL to every address.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- DATA_W, 4, RAM data width.
- RD_LAT, 1, RAM read latency in clocks from enable edge to valid `ram_dout`; legal values 1 or 2.
- CLEAR_VAL, 0, DATA_W-wide value written by the clear sequence.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  controller accepts the request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  CPU consumes the response.
- rsp_rdata  out  DATA_W  read data, held stable while rsp_valid=1.
- clear_start  in  1  single-cycle pulse; starts the clear sequence.
- clear_done  out  1  one-cycle pulse when the clear completes.
- busy  out  1  high whenever state != IDLE.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - ram_en, ram_we, ram_addr, ram_din, rsp_valid, rsp_rdata, clear_done, busy all 0.
  - Latency and clear counters cleared.
  - req_ready=0 while reset_n=0.
  - Reset mid-read or mid-clear aborts immediately; no response is produced after reset releases.
- States: IDLE, RD_WAIT, RSP, CLEAR.
- RAM-side outputs are registered. Every RAM access is a single-cycle pulse: ram_en=1 for exactly one clock per access.
- req_ready = (state==IDLE) && !clear_start && reset_n. This is the only combinational output.
- Write, accepted in cycle N:
  - Cycle N+1: ram_en=1, ram_we=1, ram_addr=req_addr, ram_din=req_wdata.
  - State stays IDLE; back-to-back writes sustain 1 per clock.
- Read, accepted in cycle N:
  - Cycle N+1: ram_en=1, ram_we=0, ram_addr=req_addr; state moves to RD_WAIT.
  - A down-counter loaded with RD_LAT counts edges. ram_dout is sampled into rsp_rdata at the edge ending cycle N+1+RD_LAT.
  - rsp_valid=1 from cycle N+2+RD_LAT; state=RSP.
- RSP:
  - rsp_valid and rsp_rdata hold until rsp_valid && rsp_ready.
  - On that edge: rsp_valid goes to 0 and state returns to IDLE; req_ready=1 the following cycle.
  - No new request is accepted while a read is outstanding (one outstanding read maximum).
- CLEAR:
  - Entered from IDLE when clear_start=1. clear_start wins over a simultaneous req_valid, which is not accepted that cycle.
  - clear_start in any other state is ignored.
  - One write per clock: ram_en=ram_we=1, ram_din=CLEAR_VAL, ram_addr counts 0 .. 2**ADDR_W-1.
  - The address counter is ADDR_W+1 bits so the terminal count is detected without wrap aliasing.
  - clear_done pulses for one cycle, in the cycle after the last write (address 2**ADDR_W-1) is driven. The return to IDLE happens in the same cycle.
  - Total busy duration = 2**ADDR_W + 1 cycles.
- Outputs during non-access cycles: ram_en=0 and ram_we=0; ram_addr and ram_din hold their last value.
- busy is registered and tracks state.

Decomposition:
- Package ram_ctrl_pkg holds:
  - state enum (IDLE, RD_WAIT, RSP, CLEAR);
  - default ADDR_W/DATA_W constants;
  - RD_LAT_MAX=2.
- A sub-module is not required. A single module with one FSM, a latency counter and a clear address counter is sufficient.

Test Plan:
- Reset held, then released → all outputs 0. req_ready=1 one cycle after release with reset_n=1 and clear_start=0.
- Write addr 0x3 data 0xA, then read addr 0x3 (RD_LAT=1) → ram_en/ram_we pulse with addr 3, din A. Read: rsp_valid rises 3 cycles after accept with rsp_rdata=0xA.
- Read with rsp_ready held low for 5 cycles → rsp_valid and rsp_rdata stable for all 5 cycles; req_ready=0 throughout; IDLE one cycle after the handshake.
- Four back-to-back writes, addresses 0–3 with data 1–4 → four consecutive ram_en=1 cycles, no bubbles, correct addr/din each cycle.
- clear_start together with req_valid=1 in IDLE → request not accepted; 16 writes of CLEAR_VAL to addresses 0..15; clear_done pulses once; subsequent reads of 0x7 and 0xF return 0.
- reset_n asserted during RD_WAIT, and separately during CLEAR at address 8 → outputs 0 immediately; after release, no stray rsp_valid or clear_done.

Source files
------------

// File: rtl/ram_access_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : ram_ctrl_pkg                                                    |
// | Purpose  : Shared types and constants for the single-port RAM access       |
// |            controller: FSM state encoding, default bus widths and the      |
// |            largest supported RAM read latency.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 4;

  // Largest RAM read latency the latency counter is sized for.
  localparam int RD_LAT_MAX = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2,
    CLEAR   = 2'd3
  } state_t;

endpackage : ram_ctrl_pkg
`default_nettype wire

// File: rtl/ram_access_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface: ram_access_ctrl_if                                              |
// | Purpose  : CPU-side request/response channel of the RAM access controller. |
// |            Request : req_valid/req_ready handshake carrying we/addr/wdata. |
// |            Response: rsp_valid/rsp_ready handshake carrying rdata.         |
// | Modports : master - CPU side (drives requests, consumes responses)         |
// |            slave  - controller side                                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface ram_access_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface : ram_access_ctrl_if
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ram_access_ctrl                                                 |
// | Purpose  : Initiator-side controller for a single-port block RAM. Turns    |
// |            CPU load/store requests into single-cycle RAM access pulses,    |
// |            absorbs the RAM's fixed read latency, returns read data on a    |
// |            valid/ready response channel and runs a hardware clear that     |
// |            writes CLEAR_VAL to every address.                              |
// | Ports    : clk         - system clock, rising edge                         |
// |            reset_n     - asynchronous active-low reset                     |
// |            cpu         - request/response channel (slave modport)          |
// |            clear_start - one-cycle pulse, starts the clear sequence        |
// |            clear_done  - one-cycle pulse after the last clear write        |
// |            busy        - registered, high whenever the FSM is not IDLE     |
// |            ram_en/ram_we/ram_addr/ram_din - registered RAM controls        |
// |            ram_dout    - RAM read data                                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                RD_LAT    = 1,          // 1 or 2
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  ram_access_ctrl_if.slave  cpu,
  input  logic              clear_start,
  output logic              clear_done,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int LAT_W = $clog2(RD_LAT_MAX + 1);

  // Clear address counter is one bit wider than the address so that the
  // value 2**ADDR_W (all addresses issued) is distinct from address 0.
  localparam logic [ADDR_W:0] CLR_END = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [ADDR_W:0]   r_clr_cnt;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_clear_done;
  logic              r_busy;

  logic              w_req_ready;

  // clear_start has priority over a request arriving in the same cycle.
  assign w_req_ready = (r_state == IDLE) && !clear_start && reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_lat_cnt    <= '0;
      r_clr_cnt    <= '0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_din    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_clear_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // RAM enables and clear_done are pulses; address/data hold otherwise.
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_clear_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (clear_start) begin
            // First clear write (address 0) is issued on entry.
            r_state    <= CLEAR;
            r_busy     <= 1'b1;
            r_ram_en   <= 1'b1;
            r_ram_we   <= 1'b1;
            r_ram_addr <= '0;
            r_ram_din  <= CLEAR_VAL;
            r_clr_cnt  <= (ADDR_W + 1)'(1);
          end else if (cpu.req_valid) begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= cpu.req_we;
            r_ram_addr <= cpu.req_addr;
            if (cpu.req_we) begin
              r_ram_din <= cpu.req_wdata;
            end else begin
              r_state   <= RD_WAIT;
              r_busy    <= 1'b1;
              r_lat_cnt <= LAT_W'(RD_LAT);
            end
          end
        end

        RD_WAIT: begin
          // Counter reaches zero on the edge where ram_dout becomes valid
          // (RD_LAT edges after the enable edge); capture on the next one.
          if (r_lat_cnt == '0) begin
            r_rsp_rdata <= ram_dout;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end

        RSP: begin
          if (cpu.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end

        CLEAR: begin
          if (r_clear_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_clr_cnt == CLR_END) begin
            r_clear_done <= 1'b1;
          end else begin
            r_ram_en   <= 1'b1;
            r_ram_we   <= 1'b1;
            r_ram_addr <= r_clr_cnt[ADDR_W-1:0];
            r_ram_din  <= CLEAR_VAL;
            r_clr_cnt  <= r_clr_cnt + (ADDR_W + 1)'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.req_ready = w_req_ready;
  assign cpu.rsp_valid = r_rsp_valid;
  assign cpu.rsp_rdata = r_rsp_rdata;
  assign clear_done    = r_clear_done;
  assign busy          = r_busy;
  assign ram_en        = r_ram_en;
  assign ram_we        = r_ram_we;
  assign ram_addr      = r_ram_addr;
  assign ram_din       = r_ram_din;

endmodule : ram_access_ctrl
`default_nettype wire
